// File: rtl/inst_mem_pkg.sv
// Shared types and address helpers for the loadable instruction memory.
// Address checks are done on a 64-bit zero-extended copy of the byte address
// so one function serves both the load and fetch ports regardless of ADDR_W.
package inst_mem_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } inst_mem_state_t;

  // Word returned when no valid fetch result is held.
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

  // Working width of the address helpers; ADDR_W must not exceed it.
  localparam int CHK_W = 64;

  // Word index of a byte address (byte offset dropped).
  function automatic logic [CHK_W-1:0] word_index(input logic [CHK_W-1:0] addr);
    return addr >> 2;
  endfunction

  // Aligned to a word and word index strictly below limit.
  function automatic logic addr_ok(input logic [CHK_W-1:0] addr,
                                   input logic [CHK_W-1:0] limit);
    return (addr[1:0] == 2'b00) && (word_index(addr) < limit);
  endfunction

endpackage

// File: rtl/inst_ram.sv
// DEPTH x DATA_W single-clock RAM: one synchronous write port and one
// registered read port. The read register only updates when i_re is high,
// so the last read word is held otherwise. Contents are never reset.
module inst_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port with read enable; holds when not enabled.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_memory.sv
// Loadable instruction memory for the IF stage. In LOAD the program is
// written word by word through the ld_* port; in RUN the ld_* port is
// ignored and fetches are served with one cycle of latency.
//
// Handshake: a fetch is taken on a rising edge when running, fetch_req=1,
// stall=0 and ld_start=0; its result (instruction or NOP with addr_err)
// appears on inst/inst_valid right after that edge. stall=1 freezes
// inst/inst_valid/addr_err whatever the state. There is no back-pressure
// on the load port: every ld_en in LOAD is either written or flagged on
// ld_err one cycle later.
module instruction_memory
  import inst_mem_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(DEFAULT_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_done,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err,
  output logic              running
);

  localparam int IDX_W = $clog2(DEPTH);

  inst_mem_state_t r_state;
  logic [IDX_W:0]  r_len;
  logic            r_ld_err;
  logic            r_valid;
  logic            r_bad;       // inst shows NOP_WORD instead of the RAM word
  logic            r_addr_err;

  logic [CHK_W-1:0]  w_ld_addr_ext;
  logic [CHK_W-1:0]  w_fetch_addr_ext;
  logic [IDX_W-1:0]  w_ld_idx;
  logic [IDX_W-1:0]  w_fetch_idx;
  logic [IDX_W:0]    w_len_cand;
  logic              w_in_load;
  logic              w_in_run;
  logic              w_ld_ok;
  logic              w_fetch_ok;
  logic              w_ld_write;
  logic              w_ld_reject;
  logic              w_fetch_fire;
  logic              w_ram_re;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_ld_addr_ext    = CHK_W'(ld_addr);
  assign w_fetch_addr_ext = CHK_W'(fetch_addr);
  assign w_ld_idx         = IDX_W'(word_index(w_ld_addr_ext));
  assign w_fetch_idx      = IDX_W'(word_index(w_fetch_addr_ext));
  assign w_len_cand       = {1'b0, w_ld_idx} + {{IDX_W{1'b0}}, 1'b1};

  assign w_in_load = (r_state == LOAD);
  assign w_in_run  = (r_state == RUN);

  // Writes must land inside the RAM; fetches must land inside the loaded program.
  assign w_ld_ok    = addr_ok(w_ld_addr_ext, CHK_W'(DEPTH));
  assign w_fetch_ok = addr_ok(w_fetch_addr_ext, CHK_W'(r_len));

  assign w_ld_write   = !rst && w_in_load && ld_en && w_ld_ok;
  assign w_ld_reject  = w_in_load && ld_en && !w_ld_ok;
  // ld_start beats a simultaneous fetch: the fetch is dropped.
  assign w_fetch_fire = w_in_run && fetch_req && !ld_start && !stall;
  assign w_ram_re     = !rst && w_fetch_fire && w_fetch_ok;

  inst_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ld_write),
    .i_waddr (w_ld_idx),
    .i_wdata (ld_data),
    .i_re    (w_ram_re),
    .i_raddr (w_fetch_idx),
    .o_rdata (w_ram_rdata)
  );

  // LOAD/RUN mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      case (r_state)
        LOAD:    if (ld_done)  r_state <= RUN;
        RUN:     if (ld_start) r_state <= LOAD;
        default: r_state <= LOAD;
      endcase
    end
  end

  // Program length: high-water mark of accepted write indices, cleared on re-entry to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= '0;
    end else if (w_in_run && ld_start) begin
      r_len <= '0;
    end else if (w_ld_write && (w_len_cand > r_len)) begin
      r_len <= w_len_cand;
    end
  end

  // One-cycle pulse flagging a rejected load write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= w_ld_reject;
    end
  end

  // Fetch result flags: capture on a taken fetch, freeze on stall, clear otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_bad      <= 1'b1;
      r_addr_err <= 1'b0;
    end else if (stall) begin
      r_valid    <= r_valid;
      r_bad      <= r_bad;
      r_addr_err <= r_addr_err;
    end else if (w_fetch_fire) begin
      r_valid    <= 1'b1;
      r_bad      <= !w_fetch_ok;
      r_addr_err <= !w_fetch_ok;
    end else begin
      r_valid    <= 1'b0;
      r_addr_err <= 1'b0;
    end
  end

  assign inst       = r_bad ? NOP_WORD : w_ram_rdata;
  assign inst_valid = r_valid;
  assign addr_err   = r_addr_err;
  assign ld_err     = r_ld_err;
  assign running    = w_in_run;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: load, fetch, error, stall, reload
// and mid-run reset scenarios with hand-computed expected values.
module tb_instruction_memory;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              ld_start;
  logic              ld_done;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              addr_err;
  logic              running;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_memory #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_done    (ld_done),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_err     (ld_err),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .stall      (stall),
    .inst       (inst),
    .inst_valid (inst_valid),
    .addr_err   (addr_err),
    .running    (running)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] e_inst,
                           input logic e_valid, input logic e_err);
    chk({tag, ".inst"},  inst, e_inst);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(e_valid));
    chk({tag, ".err"},   32'(addr_err),   32'(e_err));
  endtask

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_done = 1'b0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    chk_fetch("reset", NOP, 1'b0, 1'b0);
    chk("reset.ld_err",  32'(ld_err),  32'd0);
    chk("reset.running", 32'(running), 32'd0);

    // Fetch while in LOAD is not served
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk("load_fetch.valid", 32'(inst_valid), 32'd0);
    fetch_req = 1'b0;

    // Load two words, then an out-of-range write
    ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'h8001_060A;
    step();
    chk("ld0.ld_err", 32'(ld_err), 32'd0);
    ld_addr = 32'd4; ld_data = 32'h0401_1000;
    step();
    ld_addr = 32'(4 * DEPTH); ld_data = 32'hDEAD_BEEF;
    step();
    chk("ld_oor.ld_err", 32'(ld_err), 32'd1);
    ld_en = 1'b0;
    step();
    chk("ld_oor.pulse_end", 32'(ld_err), 32'd0);

    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    chk("run.running", 32'(running), 32'd1);

    // Back-to-back fetches, beyond-len and misaligned
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk_fetch("f0", 32'h8001_060A, 1'b1, 1'b0);
    fetch_addr = 32'd4;
    step();
    chk_fetch("f4", 32'h0401_1000, 1'b1, 1'b0);
    fetch_addr = 32'd8;
    step();
    chk_fetch("f8_len", NOP, 1'b1, 1'b1);
    fetch_addr = 32'd2;
    step();
    chk_fetch("f2_mis", NOP, 1'b1, 1'b1);
    fetch_req = 1'b0;
    step();
    chk_fetch("idle", NOP, 1'b0, 1'b0);

    // Stall freezes a rejected result while the address moves
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk_fetch("pre_stall0", 32'h8001_060A, 1'b1, 1'b0);
    fetch_addr = 32'd8;
    step();
    chk_fetch("pre_stall8", NOP, 1'b1, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(4 * (i % 2));
      step();
      chk_fetch("stall", NOP, 1'b1, 1'b1);
    end
    stall = 1'b0; fetch_addr = 32'd4;
    step();
    chk_fetch("post_stall", 32'h0401_1000, 1'b1, 1'b0);

    // ld_start wins over a simultaneous fetch
    ld_start = 1'b1; fetch_addr = 32'd0;
    step();
    ld_start = 1'b0;
    chk("ldstart.running", 32'(running), 32'd0);
    chk_fetch("ldstart", 32'h0401_1000, 1'b0, 1'b0);
    step();
    chk("load_fetch2.valid", 32'(inst_valid), 32'd0);
    fetch_req = 1'b0;

    // Reload a single word; misaligned write is rejected
    ld_en = 1'b1; ld_addr = 32'd6; ld_data = 32'h7777_7777;
    step();
    chk("ld_mis.ld_err", 32'(ld_err), 32'd1);
    ld_addr = 32'd0; ld_data = 32'h1111_2222;
    step();
    ld_en = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    chk("rerun.running", 32'(running), 32'd1);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk_fetch("re_f0", 32'h1111_2222, 1'b1, 1'b0);
    fetch_addr = 32'd4;
    step();
    chk_fetch("re_f4_len", NOP, 1'b1, 1'b1);

    // Reset mid-fetch
    fetch_addr = 32'd0; rst = 1'b1;
    step();
    chk_fetch("rst_mid", NOP, 1'b0, 1'b0);
    chk("rst_mid.running", 32'(running), 32'd0);
    // Write presented under reset is discarded
    fetch_req = 1'b0; ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'h5555_5555;
    step();
    rst = 1'b0; ld_en = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk_fetch("post_rst_f0", NOP, 1'b1, 1'b1);
    fetch_req = 1'b0; ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_en = 1'b1; ld_addr = 32'd4; ld_data = 32'hCAFE_0004;
    step();
    ld_en = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk_fetch("retain_f0", 32'h1111_2222, 1'b1, 1'b0);
    fetch_addr = 32'd4;
    step();
    chk_fetch("retain_f4", 32'hCAFE_0004, 1'b1, 1'b0);
    fetch_req = 1'b0;
    step();
    chk_fetch("final_idle", 32'hCAFE_0004, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
